// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared pattern-mode and bounce-direction encodings for led_pattern
package led_pkg;

  typedef enum logic [1:0] {
    MODE_ROT_L  = 2'd0,
    MODE_ROT_R  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BAR    = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

endpackage

// File: rtl/tick_div.sv
// rtl/tick_div.sv - enable-gated prescaler, one tick every DIV enabled cycles
module tick_div #(
  parameter int DIV = 500
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] cnt;

  assign tick = en & (cnt == LAST);

  // clr wins over en so a restart also works while paused
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern.sv
// rtl/led_pattern.sv - selectable rotate/bounce/bar LED pattern generator with step and cycle strobes
module led_pattern
  import led_pkg::*;
#(
  parameter int N_LED    = 16,
  parameter int TICK_DIV = 500,
  parameter int POS_W    = $clog2(N_LED + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [N_LED-1:0] led,
  output logic             step,
  output logic             cycle_done,
  output logic [POS_W-1:0] pos
);

  localparam logic [POS_W-1:0] LAST = POS_W'(N_LED - 1);
  localparam logic [POS_W-1:0] FULL = POS_W'(N_LED);

  mode_e            mode_q;
  dir_e             dir, dir_nxt;
  logic [POS_W-1:0] pos_nxt;
  logic             mode_chg, tick, adv, done_nxt;
  logic [N_LED-1:0] led_nxt;

  assign mode_chg = (mode != mode_q);
  assign adv      = tick & ~mode_chg;

  tick_div #(.DIV(TICK_DIV)) u_tick_div (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (mode_chg),
    .tick  (tick)
  );

  always_comb begin
    pos_nxt  = pos;
    dir_nxt  = dir;
    done_nxt = 1'b0;
    if (mode_chg) begin
      pos_nxt = '0;
      dir_nxt = DIR_UP;
    end else if (tick) begin
      case (mode_q)
        MODE_ROT_L: begin
          if (pos == LAST) begin
            pos_nxt  = '0;
            done_nxt = 1'b1;
          end else begin
            pos_nxt = pos + 1'b1;
          end
        end
        MODE_ROT_R: begin
          if (pos == '0) begin
            pos_nxt  = LAST;
            done_nxt = 1'b1;
          end else begin
            pos_nxt = pos - 1'b1;
          end
        end
        MODE_BOUNCE: begin
          // turn around on arrival so an endpoint is never shown twice
          if (dir == DIR_UP) begin
            pos_nxt = pos + 1'b1;
            if (pos == LAST - 1'b1) dir_nxt = DIR_DN;
          end else begin
            pos_nxt = pos - 1'b1;
            if (pos == POS_W'(1)) begin
              dir_nxt  = DIR_UP;
              done_nxt = 1'b1;
            end
          end
        end
        MODE_BAR: begin
          if (pos == FULL) begin
            pos_nxt  = '0;
            done_nxt = 1'b1;
          end else begin
            pos_nxt = pos + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // a BAR level of N_LED shifts the one out, so the subtraction yields all ones
  always_comb begin
    led_nxt = N_LED'(1) << pos;
    if (mode_q == MODE_BAR) led_nxt = (N_LED'(1) << pos) - N_LED'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q     <= MODE_ROT_L;
      pos        <= '0;
      dir        <= DIR_UP;
      led        <= '0;
      step       <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      mode_q     <= mode_e'(mode);
      pos        <= pos_nxt;
      dir        <= dir_nxt;
      led        <= led_nxt;
      step       <= adv;
      cycle_done <= done_nxt;
    end
  end

endmodule
